pip_hazard_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Sits directly upstream of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register, and drives their we/srst_n pins.
- Detects load-use hazards, taken-branch flushes and data-memory wait states, and produces forwarding selects.
- Supervises memory wait states with a timeout FSM and keeps stall/flush performance counters.

---
 rtl/pip_pkg.sv | 19 +
 rtl/pip_fwd_unit.sv | 26 ++
 rtl/pip_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pip_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pip_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding select
// codes, controller FSM state encoding and the default register-index width.
package pip_pkg;

  localparam int REG_AW_DEF = 5;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Memory-wait supervisor states
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } pip_state_e;

endpackage

// File: rtl/pip_fwd_unit.sv
// Forwarding compare for one ALU operand. The youngest producer (EX/MEM)
// wins over MEM/WB; r0 is never forwarded because it is hard-wired zero.
module pip_fwd_unit
  import pip_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  // Pick the nearest in-flight writer of src, else the register file
  always_comb begin
    sel = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline. Drives we/srst_n of
// the PC and the four pipeline registers, produces forwarding selects,
// supervises data-memory wait states and counts stall/flush cycles.
//
// Memory handshake: the MEM stage raises mem_req for every cycle it owns a
// data-memory access; the access completes in the cycle mem_ready is seen
// together with mem_req. Each cycle with mem_req=1 and mem_ready=0 is a wait
// state, and mem_ready without mem_req is ignored.
module pip_hazard_ctrl
  import pip_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_srst_n,
  output logic              idex_we,
  output logic              idex_srst_n,
  output logic              exmem_we,
  output logic              exmem_srst_n,
  output logic              memwb_we,
  output logic              memwb_srst_n,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [1:0]        state_dbg
);

  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

  pip_state_e state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       mwait, lu, br;
  logic       flush_any;

  assign mwait = mem_req & ~mem_ready;
  assign lu    = ex_mem_read & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign br    = ex_branch_taken;

  assign mem_err   = (state == ERR);
  assign state_dbg = state;

  pip_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src(ex_rs), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(fwd_a)
  );

  pip_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src(ex_rt), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(fwd_b)
  );

  // Supervisor state and wait-cycle counter
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next state: count consecutive wait cycles, trip ERR on one past TIMEOUT
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (mwait) begin
          state_nxt = WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      WAIT: begin
        if (!mwait) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == TIMEOUT_W) begin
          state_nxt = ERR;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Priority mux: frozen > memory wait > taken branch > load-use > pass
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_srst_n  = 1'b1;
    idex_we      = 1'b1;
    idex_srst_n  = 1'b1;
    exmem_we     = 1'b1;
    exmem_srst_n = 1'b1;
    memwb_we     = 1'b1;
    memwb_srst_n = 1'b1;
    if (state == ERR) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else if (mwait) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_we      = 1'b0;
      exmem_we     = 1'b0;
      memwb_srst_n = 1'b0;
    end else if (br) begin
      // The load-use victim sits on the wrong path, so br wins over lu
      ifid_srst_n = 1'b0;
      idex_srst_n = 1'b0;
    end else if (lu) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_srst_n = 1'b0;
    end
  end

  assign flush_any = ~(ifid_srst_n & idex_srst_n & exmem_srst_n & memwb_srst_n);

  // Performance counters, wrapping at 2^CNT_W
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_we) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_any) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Self-checking bench for pip_hazard_ctrl: a per-register action model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pip_hazard_ctrl;
  import pip_pkg::*;

  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic ex_mem_read, ex_branch_taken, mem_reg_write, wb_reg_write, mem_req, mem_ready;
  logic pc_we, ifid_we, ifid_srst_n, idex_we, idex_srst_n;
  logic exmem_we, exmem_srst_n, memwb_we, memwb_srst_n;
  logic [1:0] fwd_a, fwd_b, state_dbg;
  logic mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pip_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_srst_n(ifid_srst_n),
    .idex_we(idex_we), .idex_srst_n(idex_srst_n),
    .exmem_we(exmem_we), .exmem_srst_n(exmem_srst_n),
    .memwb_we(memwb_we), .memwb_srst_n(memwb_srst_n),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each register is told to PASS, HOLD or take a BUBBLE; the supervisor is
  // modelled as a run-length of consecutive wait cycles plus a sticky error.
  typedef enum int {A_PASS, A_HOLD, A_BUB} act_e;
  act_e act [5];                       // 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB
  bit   m_err;
  int   m_consec;
  logic [CNT_W-1:0] m_stall, m_flush;
  bit   p_valid, p_err;
  int   p_consec;
  logic [CNT_W-1:0] p_stall, p_flush;
  logic [8:0] exp_ctrl, got_ctrl;
  logic [1:0] exp_st;
  bit   c_mw, c_lu, c_bub;

  function automatic logic [1:0] model_fwd(input logic [REG_AW-1:0] src);
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic we_of(input act_e a);
    return a != A_HOLD;
  endfunction

  function automatic logic srst_of(input act_e a);
    return a != A_BUB;
  endfunction

  // Compare DUT against the model mid-cycle, then stage the model's next state
  always @(negedge clk) begin
    if (arst_n) begin
      c_mw = mem_req && !mem_ready;
      c_lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
      for (int i = 0; i < 5; i++) act[i] = A_PASS;
      if (m_err) begin
        for (int i = 0; i < 5; i++) act[i] = A_HOLD;
      end else if (c_mw) begin
        for (int i = 0; i < 4; i++) act[i] = A_HOLD;
        act[4] = A_BUB;
      end else if (ex_branch_taken) begin
        act[1] = A_BUB;
        act[2] = A_BUB;
      end else if (c_lu) begin
        act[0] = A_HOLD;
        act[1] = A_HOLD;
        act[2] = A_BUB;
      end
      exp_ctrl = {we_of(act[0]), we_of(act[1]), srst_of(act[1]), we_of(act[2]), srst_of(act[2]),
                  we_of(act[3]), srst_of(act[3]), we_of(act[4]), srst_of(act[4])};
      got_ctrl = {pc_we, ifid_we, ifid_srst_n, idex_we, idex_srst_n,
                  exmem_we, exmem_srst_n, memwb_we, memwb_srst_n};
      exp_st = m_err ? ERR : (m_consec > 0 ? WAIT : RUN);
      chk("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
      chk("fwd", 32'({fwd_a, fwd_b}), 32'({model_fwd(ex_rs), model_fwd(ex_rt)}));
      chk("mem_err", 32'(mem_err), 32'(m_err));
      chk("state", 32'(state_dbg), 32'(exp_st));
      chk("cnts", 32'({stall_cnt, flush_cnt}), 32'({m_stall, m_flush}));
      c_bub = 1'b0;
      for (int i = 1; i < 5; i++) if (act[i] == A_BUB) c_bub = 1'b1;
      p_stall  = m_stall + CNT_W'(act[0] == A_HOLD);
      p_flush  = m_flush + CNT_W'(c_bub);
      p_err    = m_err || (c_mw && m_consec == TIMEOUT);
      p_consec = c_mw ? m_consec + 1 : 0;
      p_valid  = 1'b1;
    end
  end

  // Commit the staged model state at the clock edge; clear it on reset
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_err = 0; m_consec = 0; m_stall = '0; m_flush = '0; p_valid = 0;
    end else if (p_valid) begin
      m_err = p_err; m_consec = p_consec; m_stall = p_stall; m_flush = p_flush;
      p_valid = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    arst_n = 0;
    set_idle();
    #1;
    chk("rst_state", 32'(state_dbg), 32'(RUN));
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'd0);
    @(posedge clk);
    #1;
    arst_n = 1;
  endtask

  typedef struct {
    logic [4:0] rs, rt, mrd, wrd;
    logic mw, ww;
    logic [1:0] ea, eb;
  } fwd_vec_t;

  fwd_vec_t fv [8];

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    fv[0] = '{5'd3, 5'd0, 5'd3, 5'd3, 1'b1, 1'b1, 2'b10, 2'b00};
    fv[1] = '{5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 2'b00, 2'b00};
    fv[2] = '{5'd3, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 2'b10, 2'b01};
    fv[3] = '{5'd3, 5'd7, 5'd3, 5'd3, 1'b0, 1'b1, 2'b01, 2'b00};
    fv[4] = '{5'd9, 5'd9, 5'd4, 5'd9, 1'b1, 1'b1, 2'b01, 2'b01};
    fv[5] = '{5'd12, 5'd12, 5'd12, 5'd12, 1'b1, 1'b0, 2'b10, 2'b10};
    fv[6] = '{5'd5, 5'd6, 5'd5, 5'd6, 1'b0, 1'b0, 2'b00, 2'b00};
    fv[7] = '{5'd31, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 2'b10, 2'b10};

    step();
    do_reset();

    // Load-use on rs
    ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    chk("lu_ctrl", 32'({pc_we, ifid_we, idex_we, idex_srst_n, exmem_we, memwb_we}), 32'b001011);
    step();
    chk("lu_cnts", 32'({stall_cnt, flush_cnt}), 32'h11);
    // Load-use on rt, then load to r0 (no hazard), then non-load
    id_rs = 5'd1; id_rt = 5'd5;
    step();
    ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    chk("lu_r0_pc_we", 32'(pc_we), 32'd1);
    step();
    ex_mem_read = 0; ex_rd = 5'd6; id_rs = 5'd6;
    step();

    // Branch and load-use together: branch wins
    ex_mem_read = 1; ex_rd = 5'd6; ex_branch_taken = 1;
    #1;
    chk("br_lu_ctrl", 32'({pc_we, ifid_we, ifid_srst_n, idex_we, idex_srst_n, exmem_we, memwb_we}),
        32'b1101011);
    step();
    set_idle();

    // Three-cycle memory wait with forwarding active
    do_reset();
    mem_req = 1; mem_ready = 0; ex_rs = 5'd3; mem_rd = 5'd3; mem_reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_ctrl", 32'({pc_we, memwb_we, memwb_srst_n, fwd_a}), 32'b01010);
      step();
    end
    mem_ready = 1;
    #1;
    chk("mw_done_pc_we", 32'(pc_we), 32'd1);
    step();
    chk("mw_done", 32'({state_dbg, mem_err, stall_cnt, flush_cnt}), 32'({RUN, 1'b0, 4'd3, 4'd3}));
    set_idle();

    // Exactly TIMEOUT wait cycles finish normally; branch shadowed by wait
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      ex_branch_taken = (i == 4);
      step();
    end
    mem_ready = 1; ex_branch_taken = 0;
    step();
    chk("wait16_ok", 32'({state_dbg, mem_err}), 32'({RUN, 1'b0}));
    set_idle();

    // One more wait cycle than TIMEOUT trips ERR
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < TIMEOUT + 1; i++) step();
    chk("tmo_err", 32'({mem_err, state_dbg}), 32'({1'b1, ERR}));
    chk("tmo_cnts", 32'({stall_cnt, flush_cnt}), 32'h11);
    mem_ready = 1; ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 5'd2; id_rs = 5'd2;
    #1;
    chk("err_frozen", 32'({pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                           ifid_srst_n, idex_srst_n, exmem_srst_n, memwb_srst_n}), 32'h00f);
    step();
    step();
    chk("err_cnts", 32'({mem_err, stall_cnt, flush_cnt}), 32'h131);
    #2;
    arst_n = 0;
    #1;
    chk("err_async_rst", 32'({mem_err, state_dbg, stall_cnt}), 32'({1'b0, RUN, 4'd0}));
    step();
    arst_n = 1;
    set_idle();

    // Forwarding table
    for (int k = 0; k < 8; k++) begin
      ex_rs = fv[k].rs; ex_rt = fv[k].rt; mem_rd = fv[k].mrd; wb_rd = fv[k].wrd;
      mem_reg_write = fv[k].mw; wb_reg_write = fv[k].ww;
      #1;
      chk($sformatf("fwd_vec%0d", k), 32'({fwd_a, fwd_b}), 32'({fv[k].ea, fv[k].eb}));
      step();
    end
    set_idle();

    // Counter wrap: 16 load-use stalls bring both counters back to zero
    do_reset();
    ex_mem_read = 1; ex_rd = 5'd8; id_rt = 5'd8;
    for (int i = 0; i < 15; i++) step();
    chk("cnt_15", 32'({stall_cnt, flush_cnt}), 32'hff);
    step();
    chk("cnt_wrap", 32'({stall_cnt, flush_cnt}), 32'h00);
    set_idle();

    // Mixed traffic over a small register range, checked by the model
    for (int i = 0; i < 60; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      ex_mem_read = 1'($urandom_range(0, 1)); ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
      mem_req = 1'($urandom_range(0, 1)); mem_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    set_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
